// File: rtl/poke_pkg.sv
// Display-mode encodings shared by the mode controller and the pixel mux.
// 00 selects the VT screen; every other code selects an element screen.
package poke_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_VT   = 2'b00;
    localparam mode_t MODE_ELE  = 2'b01;
    localparam mode_t MODE_ELE2 = 2'b10;
    localparam mode_t MODE_ELE3 = 2'b11;

    // Cyclic step through the four modes; wraps in both directions.
    function automatic mode_t mode_step(input mode_t m, input logic up);
        return up ? mode_t'(m + mode_t'(1)) : mode_t'(m - mode_t'(1));
    endfunction

endpackage

// File: rtl/poke_mode_ctrl_debounce.sv
// One push-button path: 2-flop synchronizer, hold-time debounce and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             acc_p2;
    logic             acc_p3;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            acc_p2  <= 1'b0;
            acc_p3  <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // p0/p1: metastability guard for the asynchronous button
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;

            // p2: accepted level only moves after an unbroken run of disagreement
            if (sync_p1 == acc_p2) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                acc_p2 <= ~acc_p2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // p3: rising edge of the accepted level; release yields nothing
            acc_p3 <= acc_p2;
            press  <= acc_p2 & ~acc_p3;
        end
    end

endmodule

// File: rtl/poke_mode_ctrl.sv
// Display-mode controller: button presses edit a requested mode that is
// committed to the pixel-mux select only on OLED frame boundaries.
module poke_mode_ctrl
    import poke_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int IDLE_FRAMES     = 600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btnC,
    input  logic              btnL,
    input  logic              btnR,
    input  logic              frame_begin,
    output logic [MODE_W-1:0] state,
    output logic              pending,
    output logic              mode_changed
);

    localparam int IDLE_W = $clog2(IDLE_FRAMES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_FRAMES);

    logic              press_c;
    logic              press_l;
    logic              press_r;
    logic              any_press;
    logic              timeout;
    mode_t             tgt;
    mode_t             next_tgt;
    logic [IDLE_W-1:0] idle_cnt;

    // Frame counter saturates so a long-idle screen stays ready to time out.
    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (v == IDLE_MAX) ? v : v + IDLE_W'(1);
    endfunction

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btnC),
        .press   (press_c)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btnL),
        .press   (press_l)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btnR),
        .press   (press_r)
    );

    assign any_press = press_c | press_l | press_r;
    assign timeout   = frame_begin && (state != MODE_VT) && (idle_cnt == IDLE_MAX);
    assign pending   = (tgt != state);

    // Home beats everything; opposing steps cancel; a press beats the timeout.
    always_comb begin
        next_tgt = tgt;
        if (press_c) begin
            next_tgt = MODE_VT;
        end else if (press_r && press_l) begin
            next_tgt = tgt;
        end else if (press_r) begin
            next_tgt = mode_step(tgt, 1'b1);
        end else if (press_l) begin
            next_tgt = mode_step(tgt, 1'b0);
        end else if (timeout) begin
            next_tgt = MODE_VT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt          <= MODE_VT;
            state        <= MODE_VT;
            mode_changed <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            tgt          <= next_tgt;
            mode_changed <= 1'b0;
            if (frame_begin) begin
                state        <= next_tgt;
                mode_changed <= (next_tgt != state);
            end

            if (any_press || (state == MODE_VT)) begin
                idle_cnt <= '0;
            end else if (frame_begin) begin
                idle_cnt <= sat_inc(idle_cnt);
            end
        end
    end

endmodule
